// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues start pulses to the shared iterative
// multiply/divide unit and stalls the pipeline until it completes.
module multdiv_sequencer #(
   parameter int MAX_CYCLES = 40,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_mult,
   input  logic        op_div,
   input  logic [4:0]  rd_in,
   input  logic        flush,
   input  logic        ext_stall,
   input  logic        unit_ready,
   input  logic [31:0] unit_result,
   input  logic        unit_exception,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        exception,
   output logic [4:0]  rd_out,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] BOUND = CNT_W'(MAX_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             kind_mult;
   logic [4:0]       rd_pend;
   logic             issue;
   logic             at_bound;

   // An issue is only recognised in IDLE; reset masks it so stall reads 0.
   assign issue    = (state == IDLE) & (op_mult | op_div) & ~flush & ~reset;
   assign at_bound = (cnt == BOUND);
   assign busy     = (state != IDLE);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and pipeline control outputs.
   always_comb begin
      state_nxt    = state;
      stall        = 1'b0;
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      result_valid = 1'b0;
      unique case (state)
         IDLE: begin
            stall = issue;
            if (issue) begin
               state_nxt = START;
            end
         end
         START: begin
            stall     = 1'b1;
            ctrl_MULT = kind_mult & ~flush;
            ctrl_DIV  = ~kind_mult & ~flush;
            state_nxt = flush ? IDLE : BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (flush) begin
               state_nxt = IDLE;
            end else if (unit_ready | at_bound) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            result_valid = ~flush;
            if (flush | ~ext_stall) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Busy-cycle counter: cleared in START, counts every BUSY cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state == START) begin
         cnt <= '0;
      end else if (state == BUSY) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Operation kind and destination latched at issue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         kind_mult <= 1'b0;
         rd_pend   <= 5'd0;
      end else if (issue) begin
         kind_mult <= op_mult;
         rd_pend   <= rd_in;
      end
   end

   // Captured completion; a flush leaves the previous capture intact.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result    <= 32'd0;
         exception <= 1'b0;
         rd_out    <= 5'd0;
         timeout   <= 1'b0;
      end else if (issue) begin
         timeout <= 1'b0;
      end else if (state == BUSY && !flush) begin
         if (unit_ready) begin
            result    <= unit_result;
            exception <= unit_exception;
            rd_out    <= rd_pend;
         end else if (at_bound) begin
            result    <= 32'd0;
            exception <= 1'b1;
            rd_out    <= rd_pend;
            timeout   <= 1'b1;
         end
      end
   end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Controller that sequences the shared iterative multiply/divide unit on behalf of the execute stage of the 5-stage pipeline. It accepts a mult/div issue and emits a single-cycle start pulse to the unit. It holds the pipeline stalled until the unit reports ready or a cycle bound expires, then presents the captured result and exception for exactly one pipeline advance. It also handles branch/jump flushes and external stalls that occur while an operation is in flight.

Parameters:
MAX_CYCLES, 40, busy cycles allowed before a forced timeout completion; legal range 2 to 63.
CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
clock  input  1  master clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
op_mult  input  1  execute-stage instruction is a mult.
op_div  input  1  execute-stage instruction is a div.
rd_in  input  5  destination register of the issuing instruction.
flush  input  1  kill the execute-stage instruction and any in-flight operation.
ext_stall  input  1  another hazard is holding the pipeline this cycle.
unit_ready  input  1  resultRDY from the multdiv unit.
unit_result  input  32  data_result from the multdiv unit.
unit_exception  input  1  data_exception from the multdiv unit.
ctrl_MULT  output  1  one-cycle start pulse to the unit, multiply.
ctrl_DIV  output  1  one-cycle start pulse to the unit, divide.
stall  output  1  hold PC, FD, DX and XM latches this cycle.
busy  output  1  state is not IDLE.
result_valid  output  1  result, exception and rd_out are valid; the pipeline may latch them.
result  output  32  captured result.
exception  output  1  captured exception.
rd_out  output  5  captured destination register.
timeout  output  1  the last completion was forced by MAX_CYCLES.

Behaviour:
- Reset (asynchronous, any state): go to IDLE; counter=0; all outputs 0, including result, rd_out and timeout.
- States: IDLE, START, BUSY, DONE.
- Issue: issue = (op_mult|op_div) & ~flush, evaluated in IDLE only. If op_mult and op_div are both 1, the operation is mult.
- IDLE:
  - stall = issue (combinational).
  - On issue: latch the kind (mult/div) and rd_in; clear timeout; next state START.
- START:
  - stall=1.
  - ctrl_MULT or ctrl_DIV = 1, selected by the latched kind, gated by ~flush.
  - Counter cleared.
  - Next state BUSY, or IDLE if flush.
- BUSY:
  - stall=1; counter increments every cycle.
  - If unit_ready: capture unit_result and unit_exception; next state DONE.
  - Else if counter == MAX_CYCLES-1: result=0, exception=1, timeout=1; next state DONE.
  - If unit_ready arrives on the same cycle as the bound, the ready path wins and timeout stays 0.
- DONE:
  - stall=0; result_valid = ~flush.
  - Next state IDLE unless ext_stall=1, in which case the block stays in DONE with outputs held; result_valid stays 1 every DONE cycle.
  - The instruction still in execute is not re-issued.
- Flush in START, BUSY or DONE: next state IDLE; no result_valid, no start pulse; captured result, exception and rd_out are retained. Flush in IDLE blocks the issue.
- ctrl_MULT and ctrl_DIV are never 1 together and never 1 outside START. At most one start pulse per issue.
- Latency: ready seen in BUSY cycle k (k=0 is the first BUSY cycle) gives result_valid at issue+3+k cycles.
- Back-to-back operations: the cycle after DONE is IDLE, and a new op present then issues immediately.
- busy = (state != IDLE).
- result, exception, rd_out and timeout hold their values until the next capture or reset.

Test Plan:
- Mult 7 x -3, unit model ready in BUSY cycle 31 -> stall high 34 consecutive cycles from issue; ctrl_MULT pulses exactly once, in cycle 1; result_valid in cycle 34 with result=0xFFFFFFEB, exception=0, rd_out=issue rd.
- Div 10/0, unit asserts ready and exception in BUSY cycle 2 -> result_valid cycle 5, exception=1, timeout=0, ctrl_DIV single pulse.
- Unit never ready, MAX_CYCLES=40 -> DONE after 40 BUSY cycles; result=0, exception=1, timeout=1.
- Flush in BUSY cycle 5 -> IDLE next cycle, stall drops, no result_valid, no second start pulse; a subsequent mult issues normally.
- DONE with ext_stall=1 for 3 cycles -> result_valid held 4 cycles and no re-issue; then two back-to-back ops (mult, then div) each produce exactly one start pulse and one completion.
- Reset asserted mid-BUSY, asynchronously between edges -> outputs 0 immediately; unit_ready afterwards is ignored; state IDLE.
